wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: req0 (EXU/ALU result path) and req1 (LSU load-return path).
- Accepts one request per transaction with valid/ready handshakes and round-robin priority. It registers the winner, then drives the RF write and a one-cycle commit pulse in the next cycle.
- Keeps a retired-instruction counter.
- Sits between the EXU/LSU outputs and the regfile, in place of a per-path commit controller.

---
 rtl/wb_port_arbiter_pkg.sv | 13 +
 rtl/wb_rr_arb2.sv | 22 ++
 rtl/wb_port_arbiter.sv | 102 ++++++++++
 tb/tb_wb_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter.
// FSM state encoding and requester source IDs.
package wb_port_arbiter_pkg;

  typedef enum logic {
    WB_IDLE   = 1'b0,
    WB_COMMIT = 1'b1
  } wb_state_e;

  localparam logic WB_SRC_EXU = 1'b0;
  localparam logic WB_SRC_LSU = 1'b1;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// i_valid: requests, i_last: last winner, o_gnt/o_idx: grant.
module wb_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_idx
);

  // With both or neither requesting, the one not served last is
  // granted, so an idle arbiter already points at the next in turn.
  always_comb begin
    o_idx = ~i_last;
    unique case (1'b1)
      (i_valid == 2'b01): o_idx = 1'b0;
      (i_valid == 2'b10): o_idx = 1'b1;
      default:            o_idx = ~i_last;
    endcase
    o_gnt = o_idx ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between EXU (req0) and LSU (req1).
// Ports: valid/ready/rd/wen/wdata per requester, RF write, commit, instret.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid0_i,
  output logic              ready0_o,
  input  logic [ADDR_W-1:0] rd0_i,
  input  logic              wen0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              valid1_i,
  output logic              ready1_o,
  input  logic [ADDR_W-1:0] rd1_i,
  input  logic              wen1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              commit_valid_o,
  output logic              commit_src_o,
  output logic [CNT_W-1:0]  instret_o
);

  wb_state_e         r_state;
  logic              r_last;
  logic [ADDR_W-1:0] r_rd;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic              r_src;
  logic [CNT_W-1:0]  r_instret;

  logic [1:0] w_gnt;
  logic       w_idx;
  logic       w_idle;
  logic       w_live;
  logic       w_hs;

  wb_rr_arb2 u_rr (
    .i_valid ({valid1_i, valid0_i}),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx)
  );

  // Reset masks the handshake and the commit so a COMMIT cycle
  // that overlaps reset retires nothing.
  assign w_idle = (r_state == WB_IDLE) && reset;
  assign w_live = (r_state == WB_COMMIT) && reset;

  assign ready0_o = w_idle && w_gnt[0];
  assign ready1_o = w_idle && w_gnt[1];
  assign w_hs = (valid0_i && ready0_o) ||
                (valid1_i && ready1_o);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= WB_IDLE;
      r_last    <= WB_SRC_LSU;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_src     <= WB_SRC_EXU;
      r_instret <= '0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (w_hs) begin
            r_state <= WB_COMMIT;
            r_rd    <= w_idx ? rd1_i : rd0_i;
            r_wen   <= w_idx ? wen1_i : wen0_i;
            r_wdata <= w_idx ? wdata1_i : wdata0_i;
            r_src   <= w_idx;
            r_last  <= w_idx;
          end
        end
        WB_COMMIT: begin
          r_state   <= WB_IDLE;
          r_instret <= r_instret + CNT_W'(1);
        end
      endcase
    end
  end

  // x0 writes are dropped but the instruction still retires.
  assign we_o           = w_live && r_wen && (r_rd != '0);
  assign waddr_o        = r_rd;
  assign wdata_o        = r_wdata;
  assign commit_valid_o = w_live;
  assign commit_src_o   = r_src;
  assign instret_o      = r_instret;

  function int wb_arb_event();
    return int'(commit_valid_o);
  endfunction

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed table, corner sequences,
// and random traffic against a transaction-level model.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        v0, v1, wen0, wen1;
  logic [4:0]  rd0, rd1;
  logic [31:0] wd0, wd1;

  logic        r0, r1, we, cv, cs;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [63:0] cnt;

  logic        s_r0, s_r1, s_we, s_cv, s_cs;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad = 0;

  wb_port_arbiter dut (
    .clock(clk), .reset(rst_n),
    .valid0_i(v0), .ready0_o(r0), .rd0_i(rd0),
    .wen0_i(wen0), .wdata0_i(wd0),
    .valid1_i(v1), .ready1_o(r1), .rd1_i(rd1),
    .wen1_i(wen1), .wdata1_i(wd1),
    .we_o(we), .waddr_o(wa), .wdata_o(wd),
    .commit_valid_o(cv), .commit_src_o(cs),
    .instret_o(cnt)
  );

  wb_port_arbiter #(.CNT_W(4)) dut4 (
    .clock(clk), .reset(rst_n),
    .valid0_i(v0), .ready0_o(s_r0), .rd0_i(rd0),
    .wen0_i(wen0), .wdata0_i(wd0),
    .valid1_i(v1), .ready1_o(s_r1), .rd1_i(rd1),
    .wen1_i(wen1), .wdata1_i(wd1),
    .we_o(s_we), .waddr_o(s_wa), .wdata_o(s_wd),
    .commit_valid_o(s_cv), .commit_src_o(s_cs),
    .instret_o(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0, v1;
    logic [4:0] rd0, rd1;
    logic       wen0, wen1;
    logic [1:0] rdy;
    logic       cv, src, we;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic        m_pend, m_last, m_psrc, m_pwen;
  logic [4:0]  m_prd;
  logic [31:0] m_pdata;
  logic [63:0] m_cnt;
  logic        win, er0, er1, ewe, hs0, hs1, e;
  int          n_ret;

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
    rd0 = '0; rd1 = '0; wd0 = '0; wd1 = '0;

    tbl[0] = '{1'b1,1'b0,5'd4,5'd6,1'b1,1'b1,2'b01,1'b1,1'b0,1'b1};
    tbl[1] = '{1'b1,1'b1,5'd4,5'd6,1'b1,1'b1,2'b10,1'b1,1'b1,1'b1};
    tbl[2] = '{1'b1,1'b1,5'd8,5'd9,1'b1,1'b1,2'b01,1'b1,1'b0,1'b1};
    tbl[3] = '{1'b0,1'b1,5'd8,5'd9,1'b1,1'b1,2'b10,1'b1,1'b1,1'b1};
    tbl[4] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0};
    tbl[5] = '{1'b1,1'b1,5'd3,5'd2,1'b1,1'b1,2'b01,1'b1,1'b0,1'b1};
    tbl[6] = '{1'b0,1'b0,5'd0,5'd0,1'b0,1'b0,2'b10,1'b0,1'b0,1'b0};
    tbl[7] = '{1'b0,1'b1,5'd4,5'd0,1'b1,1'b1,2'b10,1'b1,1'b1,1'b0};
    tbl[8] = '{1'b1,1'b0,5'd9,5'd1,1'b0,1'b1,2'b01,1'b1,1'b0,1'b0};
    tbl[9] = '{1'b1,1'b1,5'd2,5'd31,1'b1,1'b1,2'b10,1'b1,1'b1,1'b1};

    // reset, then idle
    tick();
    chk("rst_rdy", 64'({r1, r0}), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("idle_rdy", 64'({r1, r0}), 64'(2'b01));
      chk("idle_we", 64'(we), 64'(0));
      chk("idle_cv", 64'(cv), 64'(0));
      chk("idle_cnt", cnt, 64'(0));
      tick();
    end

    // single req0
    v0 = 1'b1; rd0 = 5'd5; wen0 = 1'b1; wd0 = 32'hDEADBEEF;
    #1;
    chk("s0_rdy", 64'(r0), 64'(1));
    tick();
    v0 = 1'b0;
    chk("s0_we", 64'(we), 64'(1));
    chk("s0_wa", 64'(wa), 64'(5));
    chk("s0_wd", 64'(wd), 64'(32'hDEADBEEF));
    chk("s0_cv", 64'(cv), 64'(1));
    chk("s0_src", 64'(cs), 64'(0));
    tick();
    chk("s0_cnt", cnt, 64'(1));
    chk("s0_cv_end", 64'(cv), 64'(0));

    // x0 write, then no-write retire
    v1 = 1'b1; rd1 = 5'd0; wen1 = 1'b1; wd1 = 32'h1111;
    #1;
    chk("x0_rdy", 64'(r1), 64'(1));
    tick();
    chk("x0_cv", 64'(cv), 64'(1));
    chk("x0_we", 64'(we), 64'(0));
    chk("x0_src", 64'(cs), 64'(1));
    rd1 = 5'd7; wen1 = 1'b0; wd1 = 32'h2222;
    #1;
    chk("cm_rdy", 64'({r1, r0}), 64'(0));
    tick();
    chk("nw_rdy", 64'(r1), 64'(1));
    tick();
    chk("nw_cv", 64'(cv), 64'(1));
    chk("nw_we", 64'(we), 64'(0));
    v1 = 1'b0;
    tick();
    chk("nw_cnt", cnt, 64'(3));

    // continuous contention alternates 0,1,...
    v0 = 1'b1; v1 = 1'b1; rd0 = 5'd1; rd1 = 5'd2;
    wen0 = 1'b1; wen1 = 1'b1; wd0 = 32'h0A; wd1 = 32'h0B;
    for (int k = 0; k < 8; k++) begin
      e = 1'(k % 2);
      #1;
      chk("ct_rdy", 64'({r1, r0}), e ? 64'(2'b10) : 64'(2'b01));
      tick();
      chk("ct_cv", 64'(cv), 64'(1));
      chk("ct_src", 64'(cs), 64'(e));
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("ct_cnt", cnt, 64'(11));

    // directed table
    n_ret = 11;
    for (int i = 0; i < 10; i++) begin
      v0 = tbl[i].v0; v1 = tbl[i].v1;
      rd0 = tbl[i].rd0; rd1 = tbl[i].rd1;
      wen0 = tbl[i].wen0; wen1 = tbl[i].wen1;
      wd0 = 32'hA0000000 + 32'(i);
      wd1 = 32'hB0000000 + 32'(i);
      #1;
      chk("tb_rdy", 64'({r1, r0}), 64'(tbl[i].rdy));
      tick();
      chk("tb_cv", 64'(cv), 64'(tbl[i].cv));
      chk("tb_we", 64'(we), 64'(tbl[i].we));
      if (tbl[i].cv) begin
        chk("tb_src", 64'(cs), 64'(tbl[i].src));
        chk("tb_wa", 64'(wa),
            64'(tbl[i].src ? tbl[i].rd1 : tbl[i].rd0));
        chk("tb_wd", 64'(wd),
            64'(tbl[i].src ? wd1 : wd0));
        v0 = 1'b0; v1 = 1'b0;
        tick();
        n_ret++;
      end
      v0 = 1'b0; v1 = 1'b0;
      chk("tb_cnt", cnt, 64'(n_ret));
    end

    // reset during COMMIT drops the pending retire
    v0 = 1'b1; rd0 = 5'd3; wen0 = 1'b1;
    #1;
    tick();
    rst_n = 1'b0; v0 = 1'b0;
    #1;
    chk("rc_cv", 64'(cv), 64'(0));
    chk("rc_we", 64'(we), 64'(0));
    tick();
    chk("rc_cnt", cnt, 64'(0));
    chk("rc_cnt4", 64'(s_cnt), 64'(0));
    chk("rc_cv2", 64'(cv), 64'(0));
    chk("rc_rdy", 64'({r1, r0}), 64'(0));
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("rc_tie", 64'({r1, r0}), 64'(2'b01));
    tick();
    chk("rc_src", 64'(cs), 64'(0));
    chk("rc_cv3", 64'(cv), 64'(1));
    v0 = 1'b0; v1 = 1'b0;
    tick();
    chk("rc_cnt2", cnt, 64'(1));

    // 4-bit counter wrap
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      v0 = 1'b1; rd0 = 5'(k); wen0 = 1'b1;
      #1;
      tick();
      v0 = 1'b0;
      tick();
      chk("wr_cnt4", 64'(s_cnt), 64'(k % 16));
      chk("wr_cnt", cnt, 64'(k));
    end

    // random traffic against the model
    do_reset();
    m_pend = 1'b0; m_last = 1'b1; m_cnt = '0;
    m_psrc = 1'b0; m_pwen = 1'b0; m_prd = '0; m_pdata = '0;
    for (int c = 0; c < 600; c++) begin
      if (!v0 && $urandom_range(0, 2) != 0) begin
        v0 = 1'b1;
        rd0 = 5'($urandom_range(0, 31));
        wen0 = 1'($urandom_range(0, 1));
        wd0 = $urandom;
      end
      if (!v1 && $urandom_range(0, 2) != 0) begin
        v1 = 1'b1;
        rd1 = 5'($urandom_range(0, 31));
        wen1 = 1'($urandom_range(0, 1));
        wd1 = $urandom;
      end
      #1;
      win = 1'b0;
      if (m_pend) begin
        er0 = 1'b0; er1 = 1'b0;
        ewe = m_pwen && (m_prd != 5'd0);
      end else begin
        if (v0 && !v1) win = 1'b0;
        else if (v1 && !v0) win = 1'b1;
        else win = !m_last;
        er0 = (win == 1'b0);
        er1 = (win == 1'b1);
        ewe = 1'b0;
      end
      chk("rn_rdy", 64'({r1, r0}), 64'({er1, er0}));
      chk("rn_rdy4", 64'({s_r1, s_r0}), 64'({er1, er0}));
      chk("rn_cv", 64'(cv), 64'(m_pend));
      chk("rn_cv4", 64'(s_cv), 64'(m_pend));
      chk("rn_we", 64'(we), 64'(ewe));
      chk("rn_we4", 64'(s_we), 64'(ewe));
      chk("rn_cnt", cnt, m_cnt);
      chk("rn_cnt4", 64'(s_cnt), 64'(m_cnt % 16));
      if (m_pend) begin
        chk("rn_src", 64'(cs), 64'(m_psrc));
        chk("rn_wa", 64'(wa), 64'(m_prd));
        chk("rn_wd", 64'(wd), 64'(m_pdata));
        chk("rn_src4", 64'(s_cs), 64'(m_psrc));
        chk("rn_wa4", 64'(s_wa), 64'(m_prd));
        chk("rn_wd4", 64'(s_wd), 64'(m_pdata));
      end
      hs0 = 1'b0; hs1 = 1'b0;
      if (m_pend) begin
        m_pend = 1'b0;
        m_cnt = m_cnt + 64'(1);
      end else if ((win == 1'b0 && v0) || (win == 1'b1 && v1)) begin
        m_pend = 1'b1;
        m_psrc = win;
        m_prd = win ? rd1 : rd0;
        m_pwen = win ? wen1 : wen0;
        m_pdata = win ? wd1 : wd0;
        m_last = win;
        hs0 = !win;
        hs1 = win;
      end
      tick();
      if (hs0) v0 = 1'b0;
      if (hs1) v1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
